// File: rtl/data_sram_slave.sv
// Data-memory responder: accepts one load/store at a time over req/addr_ok and
// completes it against a word-wide byte-strobed RAM with a data_ok pulse after LATENCY cycles.
module data_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [1:0]              size_q, size_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [1:0]              off_q, off_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             mem_q [Depth];

  logic                    accept;
  logic                    enter_resp;
  logic                    rd_load;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    misaligned;
  logic                    commit;
  logic                    unused_addr;

  // Upper address bits are deliberately dropped, so the RAM aliases.
  assign unused_addr = ^data_sram_addr[31:ADDR_WIDTH+2];

  assign accept = data_sram_req & data_sram_addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      wstrb_q <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (LATENCY == 1) ? StResp : StBusy;
      StBusy:  if (cnt_q <= 4'd1) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY = 1 the accept edge also enters RESP, so read from the live request.
  assign enter_resp = (state_d == StResp) && (state_q != StResp);
  assign rd_load    = (state_q == StIdle) ? ~data_sram_wr : ~wr_q;
  assign rd_idx     = (state_q == StIdle) ? data_sram_addr[ADDR_WIDTH+1:2] : idx_q;

  always_comb begin
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = 4'(LATENCY - 1);
      wr_d    = data_sram_wr;
      size_d  = data_sram_size;
      wstrb_d = data_sram_wstrb;
      idx_d   = data_sram_addr[ADDR_WIDTH+1:2];
      off_d   = data_sram_addr[1:0];
      wdata_d = data_sram_wdata;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (enter_resp && rd_load) rdata_d = mem_q[rd_idx];
  end

  always_comb begin
    case (size_q)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off_q[0];
      default: misaligned = |off_q;
    endcase
  end

  always_comb begin
    data_sram_addr_ok = (state_q == StIdle) && !reset;
    data_sram_data_ok = (state_q == StResp) && !reset;
    data_sram_err     = data_sram_data_ok & misaligned;
    data_sram_rdata   = reset ? 32'h0 : rdata_q;
  end

  // Writes land on the edge ending RESP; reset on that edge drops the store.
  assign commit = data_sram_data_ok & wr_q & ~misaligned;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: directed handshake/reset cases plus randomized loads and stores
// checked against a byte-tracking memory model.
module tb_data_sram_slave;

  localparam int unsigned Aw    = 10;
  localparam int unsigned Lat   = 2;
  localparam int unsigned Words = 2 ** Aw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  data_sram_slave #(
    .ADDR_WIDTH(Aw),
    .LATENCY   (Lat)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_wstrb  (wstrb),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata),
    .data_sram_err    (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference memory: word contents plus which bytes have ever been written.
  logic [31:0] mem_m   [Words];
  logic [3:0]  known_m [Words];
  logic [31:0] last_rd   = 32'h0;
  logic [31:0] last_mask = 32'hFFFF_FFFF;
  logic [31:0] last_obs  = 32'h0;

  int cyc     = 0;
  int acc_cnt = 0;
  int dok_cnt = 0;
  int acc_t[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && req && addr_ok) begin
      acc_cnt <= acc_cnt + 1;
      acc_t.push_back(cyc);
    end
    if (data_ok === 1'b1) dok_cnt <= dok_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] d);
    int unsigned idx;
    logic        mis;
    logic [31:0] exp_rd, msk;
    int          k, got;
    idx    = (a >> 2) % Words;
    mis    = (sz == 2'd1) ? a[0] : (sz >= 2'd2) ? (a[1:0] != 2'd0) : 1'b0;
    exp_rd = mem_m[idx];
    msk    = byte_mask(known_m[idx]);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; wstrb = st; addr = a; wdata = d;
    k = 0;
    while (addr_ok !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (addr_ok !== 1'b1) begin
      check_val("accept_timeout", 32'(addr_ok), 32'h1);
      req = 1'b0;
      return;
    end
    @(negedge clk);
    req = 1'b0;
    got = 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      if (data_ok === 1'b1) got = c;
      else begin
        check_val("busy_addr_ok", 32'(addr_ok), 32'h0);
        @(negedge clk);
      end
    end
    check_val("latency", 32'(got), 32'(Lat));
    if (got == 0) return;
    check_val("resp_addr_ok", 32'(addr_ok), 32'h0);
    check_val("err", 32'(err), 32'(mis));
    last_obs = rdata;
    if (!w) begin
      check_val("load_data", rdata & msk, exp_rd & msk);
      last_rd   = exp_rd;
      last_mask = msk;
    end else begin
      check_val("rdata_hold", rdata & last_mask, last_rd & last_mask);
      if (!mis) begin
        for (int i = 0; i < 4; i++) begin
          if (st[i]) begin
            mem_m[idx][8*i +: 8] = d[8*i +: 8];
            known_m[idx][i]      = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    check_val("pulse_one", 32'(data_ok), 32'h0);
    check_val("idle_addr_ok", 32'(addr_ok), 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base_a, base_d, k;
    for (int i = 0; i < int'(Words); i++) begin
      known_m[i] = 4'h0;
      mem_m[i]   = 32'h0;
    end

    // Reset held with a pending request: nothing may be accepted.
    req = 1'b1; wr = 1'b1; size = 2'd2; wstrb = 4'hF; addr = 32'h0; wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_addr_ok", 32'(addr_ok), 32'h0);
      check_val("rst_data_ok", 32'(data_ok), 32'h0);
      check_val("rst_rdata", rdata, 32'h0);
      check_val("rst_err", 32'(err), 32'h0);
    end
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    check_val("post_rst_addr_ok", 32'(addr_ok), 32'h1);
    repeat (4) @(negedge clk);
    check_val("rst_no_accept", 32'(dok_cnt), 32'h0);

    do_req(1'b1, 2'd2, 4'hF, 32'h100, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    check_val("word_lit", last_obs, 32'hDEAD_BEEF);

    do_req(1'b1, 2'd2, 4'hF, 32'h104, 32'h1122_3344);
    do_req(1'b1, 2'd2, 4'b0101, 32'h104, 32'hAABB_CCDD);
    do_req(1'b0, 2'd2, 4'h0, 32'h104, 32'h0);
    check_val("strobe_lit", last_obs, 32'h11BB_33DD);
    do_req(1'b1, 2'd2, 4'h0, 32'h104, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd2, 4'h0, 32'h104, 32'h0);

    do_req(1'b1, 2'd2, 4'hF, 32'h102, 32'h1234_5678);
    do_req(1'b0, 2'd2, 4'h0, 32'h100, 32'h0);
    check_val("mis_store_lit", last_obs, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd1, 4'h0, 32'h101, 32'h0);
    do_req(1'b0, 2'd1, 4'h0, 32'h102, 32'h0);
    do_req(1'b0, 2'd3, 4'h0, 32'h103, 32'h0);

    // Req held high across three loads: accepts land LATENCY+1 cycles apart.
    @(negedge clk);
    base_a = acc_t.size();
    base_d = dok_cnt;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h100;
    k = 0;
    while (acc_t.size() < base_a + 3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    check_val("b2b_accepts", 32'(acc_t.size() - base_a), 32'd3);
    if (acc_t.size() >= base_a + 3) begin
      check_val("b2b_gap1", 32'(acc_t[base_a+1] - acc_t[base_a]), 32'(Lat + 1));
      check_val("b2b_gap2", 32'(acc_t[base_a+2] - acc_t[base_a+1]), 32'(Lat + 1));
    end
    check_val("b2b_data_ok", 32'(dok_cnt - base_d), 32'd3);
    check_val("b2b_rdata", rdata, 32'hDEAD_BEEF);
    last_rd   = 32'hDEAD_BEEF;
    last_mask = 32'hFFFF_FFFF;

    // Reset while a store is in BUSY: the store must vanish.
    do_req(1'b1, 2'd2, 4'hF, 32'h200, 32'h5A5A_1234);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; wstrb = 4'hF; addr = 32'h200; wdata = 32'hFFFF_0000;
    base_d = dok_cnt;
    @(negedge clk);
    req   = 1'b0;
    reset = 1'b1;
    #1;
    check_val("midrst_data_ok", 32'(data_ok), 32'h0);
    check_val("midrst_addr_ok", 32'(addr_ok), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_val("midrst_no_resp", 32'(dok_cnt - base_d), 32'h0);
    check_val("midrst_rdata", rdata, 32'h0);
    last_rd   = 32'h0;
    last_mask = 32'hFFFF_FFFF;
    do_req(1'b0, 2'd2, 4'h0, 32'h200, 32'h0);
    check_val("midrst_old", last_obs, 32'h5A5A_1234);

    do_req(1'b1, 2'd2, 4'hF, 32'h1000, 32'hC0FF_EE01);
    do_req(1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
    check_val("alias_lit", last_obs, 32'hC0FF_EE01);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'h300 | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
